// File: rtl/mcycle_muldiv_unit.sv
// ============================================================================
// Module   : mcycle_muldiv_unit
// Brief    : Multi-cycle signed/unsigned shift-add multiplier and restoring
//            divider with early termination, divide-by-zero results and flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcycle_muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic             Signed,
    input  logic             Flush,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int                c_CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0]   c_LAST    = c_CW'(WIDTH - 1);
    localparam logic [1:0]        c_IDLE    = 2'd0;
    localparam logic [1:0]        c_COMPUTE = 2'd1;
    localparam logic [1:0]        c_DONE    = 2'd2;

    logic [1:0]         r_state, w_next_state;
    logic               r_op, r_sign1, r_sign2;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [c_CW-1:0]    r_cnt;

    logic [WIDTH-1:0]   w_mag1, w_mag2, w_mul_b;
    logic [WIDTH:0]     w_sum, w_rem_sh, w_diff;
    logic [2*WIDTH:0]   w_mul_full;
    logic [2*WIDTH-1:0] w_mul_acc, w_div_acc, w_prod;
    logic               w_load, w_step, w_last;

    always_comb begin
        w_mag1     = (Signed && Operand1[WIDTH-1]) ? -Operand1 : Operand1;
        w_mag2     = (Signed && Operand2[WIDTH-1]) ? -Operand2 : Operand2;
        // Multiply: add into the high half, then shift the whole accumulator right with carry.
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
        w_mul_full = {w_sum, r_acc[WIDTH-1:0]};
        w_mul_acc  = w_mul_full[2*WIDTH:1];
        w_mul_b    = r_b >> 1;
        // Remaining multiplier bits are zero, so undo the missing right shifts.
        w_prod     = w_mul_acc >> (c_LAST - r_cnt);
        // Divide: {rem,quo} shifted left, restoring trial subtraction.
        w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_diff     = w_rem_sh - {1'b0, r_b};
        if (!w_diff[WIDTH])
            w_div_acc = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        else
            w_div_acc = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        w_last     = (r_cnt == c_LAST) || (EARLY_TERM && !r_op && (w_mul_b == '0));
        w_load     = (r_state == c_IDLE) && Start && !Flush;
        w_step     = (r_state == c_COMPUTE) && !Flush;
    end

    always_comb begin
        w_next_state = r_state;
        Busy         = 1'b0;
        Done         = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (Start && !Flush) begin
                    Busy         = 1'b1;
                    w_next_state = (Operand2 == '0) ? c_DONE : c_COMPUTE;
                end
            end
            c_COMPUTE: begin
                Busy = 1'b1;
                if (Flush)
                    w_next_state = c_IDLE;
                else if (w_last)
                    w_next_state = c_DONE;
            end
            c_DONE: begin
                Done         = !Flush;
                w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            r_state <= c_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_op    <= 1'b0;
            r_sign1 <= 1'b0;
            r_sign2 <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            Result1 <= '0;
            Result2 <= '0;
        end else if (w_load) begin
            r_op    <= MCycleOp;
            r_sign1 <= Signed & Operand1[WIDTH-1];
            r_sign2 <= Signed & Operand2[WIDTH-1];
            r_a     <= w_mag1;
            r_b     <= w_mag2;
            r_cnt   <= '0;
            r_acc   <= MCycleOp ? {{WIDTH{1'b0}}, w_mag1} : '0;
            if (Operand2 == '0) begin
                Result1 <= MCycleOp ? '1 : '0;
                Result2 <= MCycleOp ? Operand1 : '0;
            end
        end else if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_op) begin
                r_acc <= w_div_acc;
            end else begin
                r_acc <= w_mul_acc;
                r_b   <= w_mul_b;
            end
            if (w_last) begin
                if (r_op) begin
                    Result1 <= (r_sign1 ^ r_sign2) ? -w_div_acc[WIDTH-1:0] : w_div_acc[WIDTH-1:0];
                    Result2 <= r_sign1 ? -w_div_acc[2*WIDTH-1:WIDTH] : w_div_acc[2*WIDTH-1:WIDTH];
                end else begin
                    {Result2, Result1} <= (r_sign1 ^ r_sign2) ? -w_prod : w_prod;
                end
            end
        end
    end

endmodule

`default_nettype wire
